corr_mac: RTL and testbench

- Consumer end of the sample-ROM streaming handshake.
- Requests one (a, b) sample pair at a time with next_add and receives it on valid_in/a_in/b_in.
- Multiplies each pair as signed values and accumulates SIG_A_SAMPLES products per lag.
- Emits one correlation value per lag; raises done after all lags.
- Sits directly between the sample ROM and the result sink (peak detector / output register).

---
 rtl/corr_mac.sv | 206 ++++++++++++++++++++
 tb/tb_corr_mac.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_mac.sv
// Streaming signed multiply-accumulate correlator: pulls (a, b) pairs, emits one sum per lag.
// Optional peak tracking (peak_val/peak_lag outputs) is enabled by defining CORR_MAC_PEAK_TRACK_EN.
module corr_mac #(
  parameter int unsigned SIG_A_SAMPLES = 20,
  parameter int unsigned SIG_B_SAMPLES = 5000,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ACC_W         = 24,
  parameter int unsigned LAG_W         = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              next_add,
  output logic [ACC_W-1:0]  corr_out,
  output logic              corr_valid,
  output logic [LAG_W-1:0]  corr_lag,
  output logic              done,
  output logic              protocol_err
`ifdef CORR_MAC_PEAK_TRACK_EN
  ,
  output logic [ACC_W-1:0]  peak_val,
  output logic [LAG_W-1:0]  peak_lag
`endif
);

  localparam int unsigned LAGS   = SIG_B_SAMPLES - SIG_A_SAMPLES + 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = (SIG_A_SAMPLES > 1) ? $clog2(SIG_A_SAMPLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIG_A_SAMPLES - 1);
  localparam logic [LAG_W-1:0] LAG_LAST = LAG_W'(LAGS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StAcc,
    StEmit,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               pend_q, pend_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LAG_W-1:0]   lag_q, lag_d;
  logic [ACC_W-1:0]   corr_out_q, corr_out_d;
  logic [LAG_W-1:0]   corr_lag_q, corr_lag_d;
  logic               corr_valid_q, corr_valid_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;

`ifdef CORR_MAC_PEAK_TRACK_EN
  logic [ACC_W-1:0]   peak_val_q, peak_val_d;
  logic [LAG_W-1:0]   peak_lag_q, peak_lag_d;
  logic               peak_seen_q, peak_seen_d;
`endif

  logic signed [PROD_W-1:0] a_ext, b_ext;

  // Widen before multiplying so the full signed product lands in PROD_W bits.
  assign a_ext = PROD_W'($signed(a_in));
  assign b_ext = PROD_W'($signed(b_in));

  always_comb begin
    state_d      = state_q;
    prod_d       = prod_q;
    pend_d       = pend_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    lag_d        = lag_q;
    corr_out_d   = corr_out_q;
    corr_lag_d   = corr_lag_q;
    corr_valid_d = 1'b0;
    done_d       = done_q;
    perr_d       = perr_q;
    next_add     = 1'b0;
`ifdef CORR_MAC_PEAK_TRACK_EN
    peak_val_d   = peak_val_q;
    peak_lag_d   = peak_lag_q;
    peak_seen_d  = peak_seen_q;
`endif

    if (valid_in && (state_q != StWait)) begin
      perr_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (ena_in) state_d = StReq;
      end
      StReq: begin
        if (ena_in) begin
          next_add = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        // Data is captured even while paused; pend_q remembers it until ena_in returns.
        if (valid_in) begin
          prod_d = a_ext * b_ext;
          pend_d = 1'b1;
        end
        if (ena_in && (valid_in || pend_q)) begin
          pend_d  = 1'b0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (ena_in) begin
          acc_d = acc_q + ACC_W'($signed(prod_q));
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = StEmit;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = StReq;
          end
        end
      end
      StEmit: begin
        if (ena_in) begin
          corr_out_d   = acc_q;
          corr_lag_d   = lag_q;
          corr_valid_d = 1'b1;
          acc_d        = '0;
          cnt_d        = '0;
          lag_d        = lag_q + LAG_W'(1);
`ifdef CORR_MAC_PEAK_TRACK_EN
          // Strict compare keeps the earliest lag on ties.
          if (!peak_seen_q || ($signed(acc_q) > $signed(peak_val_q))) begin
            peak_val_d  = acc_q;
            peak_lag_d  = lag_q;
            peak_seen_d = 1'b1;
          end
`endif
          if (lag_q == LAG_LAST) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      prod_q       <= '0;
      pend_q       <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      lag_q        <= '0;
      corr_out_q   <= '0;
      corr_lag_q   <= '0;
      corr_valid_q <= 1'b0;
      done_q       <= 1'b0;
      perr_q       <= 1'b0;
`ifdef CORR_MAC_PEAK_TRACK_EN
      peak_val_q   <= '0;
      peak_lag_q   <= '0;
      peak_seen_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prod_q       <= prod_d;
      pend_q       <= pend_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      lag_q        <= lag_d;
      corr_out_q   <= corr_out_d;
      corr_lag_q   <= corr_lag_d;
      corr_valid_q <= corr_valid_d;
      done_q       <= done_d;
      perr_q       <= perr_d;
`ifdef CORR_MAC_PEAK_TRACK_EN
      peak_val_q   <= peak_val_d;
      peak_lag_q   <= peak_lag_d;
      peak_seen_q  <= peak_seen_d;
`endif
    end
  end

  assign corr_out     = corr_out_q;
  assign corr_lag     = corr_lag_q;
  assign corr_valid   = corr_valid_q;
  assign done         = done_q;
  assign protocol_err = perr_q;
`ifdef CORR_MAC_PEAK_TRACK_EN
  assign peak_val     = peak_val_q;
  assign peak_lag     = peak_lag_q;
`endif

endmodule

// File: tb/tb_corr_mac.sv
// Scoreboard bench for corr_mac: two instances (N=4/B=6 and N=2/B=5) fed by ROM models.
module tb_corr_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 4: N=4, B=6 (3 lags)
  logic        rst_4, ena_4, valid_4;
  logic [7:0]  a_4, b_4;
  logic        next_add_4, corr_valid_4, done_4, perr_4;
  logic [23:0] corr_out_4;
  logic [3:0]  corr_lag_4;
  // Instance 2: N=2, B=5 (4 lags)
  logic        rst_2, ena_2, valid_2;
  logic [7:0]  a_2, b_2;
  logic        next_add_2, corr_valid_2, done_2, perr_2;
  logic [23:0] corr_out_2;
  logic [3:0]  corr_lag_2;
`ifdef CORR_MAC_PEAK_TRACK_EN
  logic [23:0] peak_val_4, peak_val_2;
  logic [3:0]  peak_lag_4, peak_lag_2;
`endif

  corr_mac #(
    .SIG_A_SAMPLES(4), .SIG_B_SAMPLES(6), .DATA_W(8), .ACC_W(24), .LAG_W(4)
  ) u_dut4 (
    .clk(clk), .rst(rst_4), .ena_in(ena_4), .valid_in(valid_4), .a_in(a_4), .b_in(b_4),
    .next_add(next_add_4), .corr_out(corr_out_4), .corr_valid(corr_valid_4),
    .corr_lag(corr_lag_4), .done(done_4), .protocol_err(perr_4)
`ifdef CORR_MAC_PEAK_TRACK_EN
    , .peak_val(peak_val_4), .peak_lag(peak_lag_4)
`endif
  );

  corr_mac #(
    .SIG_A_SAMPLES(2), .SIG_B_SAMPLES(5), .DATA_W(8), .ACC_W(24), .LAG_W(4)
  ) u_dut2 (
    .clk(clk), .rst(rst_2), .ena_in(ena_2), .valid_in(valid_2), .a_in(a_2), .b_in(b_2),
    .next_add(next_add_2), .corr_out(corr_out_2), .corr_valid(corr_valid_2),
    .corr_lag(corr_lag_2), .done(done_2), .protocol_err(perr_2)
`ifdef CORR_MAC_PEAK_TRACK_EN
    , .peak_val(peak_val_2), .peak_lag(peak_lag_2)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rom_a4 [4];
  logic [7:0] rom_b4 [6];
  logic [7:0] rom_a2 [2];
  logic [7:0] rom_b2 [5];

  int  k4 = 0, lag4 = 0, k2 = 0, lag2 = 0, req2 = 0;
  int  inj2 = -1;
  logic clr4 = 1'b1, clr2 = 1'b1, rec_na = 1'b0;
  int  cyc = 0;
  int  na_t [$];

  longint exp_val4 [$], exp_lag4 [$], exp_val2 [$], exp_lag2 [$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ROM model: answers one cycle after next_add with a[k], b[lag+k].
  task automatic feed4();
    forever begin
      @(negedge clk);
      if (clr4) begin
        k4 = 0; lag4 = 0;
      end else if (next_add_4) begin
        @(posedge clk); #1;
        valid_4 = 1'b1; a_4 = rom_a4[k4]; b_4 = rom_b4[lag4 + k4];
        @(posedge clk); #1;
        valid_4 = 1'b0;
        k4++;
        if (k4 == 4) begin k4 = 0; lag4++; end
      end
    end
  endtask

  // Same ROM model; request number inj2 also gets a stray strobe while the DUT is in REQ.
  task automatic feed2();
    forever begin
      @(negedge clk);
      if (clr2) begin
        k2 = 0; lag2 = 0; req2 = 0;
      end else if (next_add_2) begin
        if (req2 == inj2) begin
          valid_2 = 1'b1; a_2 = 8'd127; b_2 = 8'd127;
        end
        req2++;
        @(posedge clk); #1;
        valid_2 = 1'b1; a_2 = rom_a2[k2]; b_2 = rom_b2[lag2 + k2];
        @(posedge clk); #1;
        valid_2 = 1'b0;
        k2++;
        if (k2 == 2) begin k2 = 0; lag2++; end
      end
    end
  endtask

  task automatic mon4();
    forever begin
      @(negedge clk);
      if (corr_valid_4) begin
        if (exp_val4.size() == 0) begin
          check("d4_unexpected_corr_valid", 1, 0);
        end else begin
          check("d4_corr_out", $signed(corr_out_4), exp_val4.pop_front());
          check("d4_corr_lag", corr_lag_4, exp_lag4.pop_front());
        end
      end
    end
  endtask

  task automatic mon2();
    forever begin
      @(negedge clk);
      if (corr_valid_2) begin
        if (exp_val2.size() == 0) begin
          check("d2_unexpected_corr_valid", 1, 0);
        end else begin
          check("d2_corr_out", $signed(corr_out_2), exp_val2.pop_front());
          check("d2_corr_lag", corr_lag_2, exp_lag2.pop_front());
        end
      end
    end
  endtask

  task automatic rec_next_add();
    forever begin
      @(negedge clk);
      cyc++;
      if (rec_na && next_add_4) na_t.push_back(cyc);
    end
  endtask

  initial begin
    int n;
    rst_4 = 1'b1; ena_4 = 1'b0; valid_4 = 1'b0; a_4 = '0; b_4 = '0;
    rst_2 = 1'b1; ena_2 = 1'b0; valid_2 = 1'b0; a_2 = '0; b_2 = '0;
    fork
      feed4();
      feed2();
      mon4();
      mon2();
      rec_next_add();
    join_none

    repeat (3) @(negedge clk);
    check("rst_done", done_4, 0);
    check("rst_corr_valid", corr_valid_4, 0);
    check("rst_corr_out", corr_out_4, 0);
    check("rst_next_add", next_add_4, 0);
    check("rst_protocol_err", perr_2, 0);
    rst_4 = 1'b0; rst_2 = 1'b0; clr4 = 1'b0; clr2 = 1'b0;

    // d4 run 1: a=1, b=2 -> 8 at each of lags 0..2
    rom_a4 = '{8'd1, 8'd1, 8'd1, 8'd1};
    rom_b4 = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    for (int i = 0; i < 3; i++) begin exp_val4.push_back(8); exp_lag4.push_back(i); end
    rec_na = 1'b1;
    ena_4  = 1'b1;
    n = 0;
    while (!done_4 && n < 500) begin @(negedge clk); n++; end
    check("d4_run1_done", done_4, 1);
    rec_na = 1'b0;
    repeat (5) @(negedge clk);
    check("d4_run1_pending", exp_val4.size(), 0);
    check("d4_done_sticky", done_4, 1);
    check("d4_corr_out_hold", corr_out_4, 8);
    check("d4_corr_lag_hold", corr_lag_4, 2);
    check("d4_next_add_in_done", next_add_4, 0);
    check("d4_next_add_count", na_t.size(), 12);
    for (int i = 1; i < na_t.size(); i++) begin
      check("d4_next_add_spacing", na_t[i] - na_t[i-1], ((i % 4) == 0) ? 4 : 3);
    end

    // Reset after completion clears sticky/held outputs
    ena_4 = 1'b0; rst_4 = 1'b1; clr4 = 1'b1;
    @(negedge clk);
    check("d4_rst_done", done_4, 0);
    check("d4_rst_corr_out", corr_out_4, 0);
    check("d4_rst_corr_lag", corr_lag_4, 0);
    @(negedge clk);
    rst_4 = 1'b0; clr4 = 1'b0;

    // d4 run 2: a=b=-128, aborted by reset after two accepted pairs
    rom_a4 = '{8'h80, 8'h80, 8'h80, 8'h80};
    rom_b4 = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    ena_4 = 1'b1;
    n = 0;
    while (k4 != 2 && n < 200) begin @(negedge clk); n++; end
    check("d4_midrun_pairs", k4, 2);
    ena_4 = 1'b0; rst_4 = 1'b1; clr4 = 1'b1;
    @(negedge clk);
    check("d4_abort_next_add", next_add_4, 0);
    check("d4_abort_corr_valid", corr_valid_4, 0);
    check("d4_abort_corr_out", corr_out_4, 0);
    check("d4_abort_corr_lag", corr_lag_4, 0);
    check("d4_abort_done", done_4, 0);
    check("d4_abort_protocol_err", perr_4, 0);
    @(negedge clk);
    rst_4 = 1'b0; clr4 = 1'b0;
    for (int i = 0; i < 3; i++) begin exp_val4.push_back(65536); exp_lag4.push_back(i); end
    ena_4 = 1'b1;
    n = 0;
    while (!done_4 && n < 500) begin @(negedge clk); n++; end
    check("d4_run2_done", done_4, 1);
    repeat (3) @(negedge clk);
    check("d4_run2_pending", exp_val4.size(), 0);
    check("d4_run2_protocol_err", perr_4, 0);

    // d2 run A: a=[1,-1], b=[0,3,7,0,0], stray strobe during the second REQ
    rom_a2 = '{8'h01, 8'hFF};
    rom_b2 = '{8'd0, 8'd3, 8'd7, 8'd0, 8'd0};
    exp_val2.push_back(-3); exp_val2.push_back(-4); exp_val2.push_back(7); exp_val2.push_back(0);
    for (int i = 0; i < 4; i++) exp_lag2.push_back(i);
    inj2  = 1;
    ena_2 = 1'b1;
    n = 0;
    while (!done_2 && n < 500) begin @(negedge clk); n++; end
    check("d2_runA_done", done_2, 1);
    check("d2_protocol_err_set", perr_2, 1);
    repeat (5) @(negedge clk);
    check("d2_protocol_err_sticky", perr_2, 1);
    check("d2_runA_pending", exp_val2.size(), 0);
`ifdef CORR_MAC_PEAK_TRACK_EN
    check("d2_runA_peak_val", $signed(peak_val_2), 7);
    check("d2_runA_peak_lag", peak_lag_2, 2);
`endif

    ena_2 = 1'b0; rst_2 = 1'b1; clr2 = 1'b1; inj2 = -1;
    @(negedge clk);
    check("d2_rst_protocol_err", perr_2, 0);
    check("d2_rst_done", done_2, 0);
    @(negedge clk);
    rst_2 = 1'b0; clr2 = 1'b0;

    // d2 run B: a=[1,1] with ena_in dropping one cycle in five
    rom_a2 = '{8'h01, 8'h01};
    exp_val2.push_back(3); exp_val2.push_back(10); exp_val2.push_back(7); exp_val2.push_back(0);
    for (int i = 0; i < 4; i++) exp_lag2.push_back(i);
    ena_2 = 1'b1;
    fork
      begin
        for (int c = 0; c < 800 && !done_2; c++) begin
          @(posedge clk); #2;
          ena_2 = (c % 5) != 3;
        end
      end
    join_none
    n = 0;
    while (!done_2 && n < 800) begin @(negedge clk); n++; end
    check("d2_runB_done", done_2, 1);
    repeat (5) @(negedge clk);
    check("d2_runB_pending", exp_val2.size(), 0);
    check("d2_runB_protocol_err", perr_2, 0);
`ifdef CORR_MAC_PEAK_TRACK_EN
    check("d2_runB_peak_val", $signed(peak_val_2), 10);
    check("d2_runB_peak_lag", peak_lag_2, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
